// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access sizes and arbiter FSM states.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_type_t;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } arb_state_t;

    // Bits needed to hold a counter value in 0..max.
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; backs the wait and burst counters.
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             at_max_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign at_max_o = (cnt_q == WIDTH'(MAX));
    assign cnt_o    = cnt_q;

    // Clear wins over increment so a state entry always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU memory stage (priority)
// and a word-wide DMA master, with bounded unfairness in both directions.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_DMA_BURST = 8,
    parameter int DMA_WAIT_MAX  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic [1:0]            cpu_type_i,
    input  logic                  cpu_sign_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_stall_o,
    input  logic                  dma_req_i,
    input  logic                  dma_we_i,
    input  logic                  dma_last_i,
    input  logic [DATA_WIDTH-1:0] dma_addr_i,
    input  logic [DATA_WIDTH-1:0] dma_wdata_i,
    output logic                  dma_gnt_o,
    output logic [DATA_WIDTH-1:0] dma_rdata_o,
    output logic                  dma_rvalid_o,
    output logic                  dma_active_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [1:0]            mem_type_o,
    output logic                  mem_sign_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int WAIT_W  = cnt_width(DMA_WAIT_MAX);
    localparam int BURST_W = cnt_width(MAX_DMA_BURST);

    arb_state_t state_q, state_d;

    logic               wait_inc, wait_clr, wait_at_max;
    logic               burst_inc, burst_clr, burst_at_max;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               unused_at_max;

    assign unused_at_max = &{1'b0, wait_at_max, burst_at_max};

    arb_sat_counter #(.WIDTH(WAIT_W), .MAX(DMA_WAIT_MAX)) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (wait_inc),
        .clr_i   (wait_clr),
        .cnt_o   (wait_cnt),
        .at_max_o(wait_at_max)
    );

    arb_sat_counter #(.WIDTH(BURST_W), .MAX(MAX_DMA_BURST)) u_burst_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (burst_inc),
        .clr_i   (burst_clr),
        .cnt_o   (burst_cnt),
        .at_max_o(burst_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        burst_inc = 1'b0;
        burst_clr = 1'b0;
        case (state_q)
            S_CPU: begin
                burst_clr = 1'b1;
                if (!dma_req_i) begin
                    wait_clr = 1'b1;
                end else if (!cpu_req_i) begin
                    state_d  = S_DMA;
                    wait_clr = 1'b1;
                end else if (wait_cnt == WAIT_W'(DMA_WAIT_MAX - 1)) begin
                    // CPU is still served this cycle; DMA owns the port next.
                    state_d  = S_DMA;
                    wait_clr = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DMA: begin
                wait_clr = 1'b1;
                if (!dma_req_i || dma_last_i) begin
                    state_d = S_CPU;
                end else if (cpu_req_i && burst_cnt == BURST_W'(MAX_DMA_BURST - 1)) begin
                    state_d = S_CPU;
                end else if (cpu_req_i) begin
                    burst_inc = 1'b1;
                end else begin
                    burst_clr = 1'b1;
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    // Port mux and handshakes: zero-latency from the registered owner.
    always_comb begin
        mem_we_o     = 1'b0;
        mem_addr_o   = cpu_addr_i;
        mem_wdata_o  = cpu_wdata_i;
        mem_type_o   = cpu_type_i;
        mem_sign_o   = cpu_sign_i;
        cpu_rdata_o  = mem_rdata_i;
        cpu_stall_o  = 1'b0;
        dma_gnt_o    = 1'b0;
        dma_rdata_o  = '0;
        dma_rvalid_o = 1'b0;
        dma_active_o = (state_q == S_DMA);
        if (state_q == S_DMA) begin
            mem_we_o     = dma_req_i & dma_we_i;
            mem_addr_o   = dma_addr_i;
            mem_wdata_o  = dma_wdata_i;
            mem_type_o   = MEM_WORD;
            mem_sign_o   = 1'b0;
            cpu_rdata_o  = '0;
            cpu_stall_o  = cpu_req_i;
            dma_gnt_o    = 1'b1;
            dma_rdata_o  = mem_rdata_i;
            dma_rvalid_o = dma_req_i & ~dma_we_i;
        end else begin
            mem_we_o = cpu_req_i & cpu_we_i;
        end
        // Reset abandons any transfer and keeps writes away from memory.
        if (rst) begin
            mem_we_o    = 1'b0;
            dma_gnt_o   = 1'b0;
            cpu_stall_o = 1'b0;
        end
    end

endmodule
